// File: rtl/pixel_write_arbiter_if.sv
// Requester-side pixel bus: per-requester valid/ready plus packed x/y/colour fields.
interface pixel_write_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_x;
  logic [7*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_colour;

  modport master (output req_valid, req_x, req_y, req_colour, input req_ready);
  modport slave  (input req_valid, req_x, req_y, req_colour, output req_ready);
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port between requesters,
// with a priority clear engine that sweeps the whole screen in raster order.
module pixel_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120
) (
  input  logic                  clock,
  input  logic                  reset,
  pixel_write_arbiter_if.slave  req,
  input  logic                  clear_start,
  input  logic [2:0]            clear_colour,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  range_err,
  output logic [7:0]            x,
  output logic [6:0]            y,
  output logic [2:0]            colour,
  output logic                  plot
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {ARB, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, grant, idx;
  logic               found;
  logic [NUM_REQ-1:0] ready;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               plot_q, plot_d, done_q, done_d, err_q, err_d;

  logic [7:0] rx [NUM_REQ];
  logic [6:0] ry [NUM_REQ];
  logic [2:0] rc [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rx[i] = req.req_x[8*i +: 8];
    assign ry[i] = req.req_y[7*i +: 7];
    assign rc[i] = req.req_colour[3*i +: 3];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req.req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == ARB && !clear_start && found) ready[grant] = 1'b1;
  end
  assign req.req_ready = ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d  = CLEAR;
          x_d      = '0;
          y_d      = '0;
          colour_d = clear_colour;
          plot_d   = 1'b1;
        end else if (found) begin
          rr_ptr_d = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
          // Out-of-range pixels are consumed but never reach the adapter.
          if (int'(rx[grant]) >= WIDTH || int'(ry[grant]) >= HEIGHT) begin
            err_d = 1'b1;
          end else begin
            x_d      = rx[grant];
            y_d      = ry[grant];
            colour_d = rc[grant];
            plot_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        // x_q/y_q double as the sweep counters; colour_q holds the fill colour.
        if (int'(x_q) != WIDTH - 1) begin
          x_d    = x_q + 8'd1;
          plot_d = 1'b1;
        end else if (int'(y_q) != HEIGHT - 1) begin
          x_d    = '0;
          y_d    = y_q + 7'd1;
          plot_d = 1'b1;
        end else begin
          state_d = ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;
  assign range_err  = err_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench: vector table for arbitration/range checks, hand sequences for clear sweeps.
module tb_pixel_write_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       clear_start;
  logic [2:0] clear_colour;
  logic       clear_busy, clear_done, range_err, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  int         checks = 0;
  int         failures = 0;

  pixel_write_arbiter_if #(.NUM_REQ(2)) bus ();

  pixel_write_arbiter #(.NUM_REQ(2), .WIDTH(160), .HEIGHT(120)) dut (
    .clock(clock), .reset(reset), .req(bus),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done), .range_err(range_err),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] v;
    logic [7:0] x0; logic [6:0] y0; logic [2:0] c0;
    logic [7:0] x1; logic [6:0] y1; logic [2:0] c1;
    logic [1:0] rdy;
    logic       plot;
    logic [7:0] ex; logic [6:0] ey; logic [2:0] ec;
    logic       err;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one clear sweep; optionally re-pulses clear_start or asserts reset mid-sweep.
  task automatic run_clear(input int pulse_at, input int reset_at, input logic [1:0] exp_rdy_after);
    int n = 0, bad = 0, done_cnt = 0, cyc = 0;
    logic [7:0] ex = 0;
    logic [6:0] ey = 0;
    bus.req_valid = 2'b11;
    clear_colour  = 3'd2;
    clear_start   = 1'b1;
    #1;
    chk("clr_start_ready", bus.req_ready, 2'b00);
    tick();
    clear_start  = 1'b0;
    clear_colour = 3'd5;
    chk("clr_busy_e0", clear_busy, 1'b1);
    chk("clr_first_plot", {plot, x, y, colour}, {1'b1, 8'd0, 7'd0, 3'd2});
    while (cyc < 19300) begin
      if (clear_done) begin
        done_cnt++;
        break;
      end
      if (plot) begin
        if (x !== ex || y !== ey || colour !== 3'd2) bad++;
        n++;
        if (ex == 8'd159) begin
          ex = 0;
          ey++;
        end else ex++;
      end
      if (bus.req_ready !== 2'b00 || clear_busy !== 1'b1) bad++;
      clear_start = (n == pulse_at);
      if (reset_at >= 0 && n == reset_at) begin
        reset = 1'b1;
        clear_start = 1'b0;
        tick();
        chk("rst_mid_outputs", {plot, x, y, colour}, 19'd0);
        chk("rst_mid_flags", {clear_busy, clear_done, range_err}, 3'b000);
        reset = 1'b0;
        #1;
        chk("rst_mid_rr_ptr", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 20; i++) begin
          tick();
          if (clear_done) done_cnt++;
        end
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_bad_before", bad, 0);
        return;
      end
      tick();
      cyc++;
    end
    chk("clr_pixel_count", n, 19200);
    chk("clr_pixel_order", bad, 0);
    chk("clr_last_xy", {ex, ey}, {8'd0, 7'd120});
    chk("clr_done_seen", done_cnt, 1);
    chk("clr_end_flags", {plot, clear_busy}, 2'b00);
    chk("clr_end_ready", bus.req_ready, exp_rdy_after);
    tick();
    chk("clr_done_one_cycle", clear_done, 1'b0);
    bus.req_valid = 2'b00;
  endtask

  initial begin
    vt[0]  = '{2'b01, 10, 20, 5, 0, 0, 0, 2'b01, 1, 10, 20, 5, 0};
    vt[1]  = '{2'b00, 10, 20, 5, 0, 0, 0, 2'b00, 0, 10, 20, 5, 0};
    vt[2]  = '{2'b11, 1, 2, 1, 3, 4, 6, 2'b10, 1, 3, 4, 6, 0};
    vt[3]  = '{2'b11, 1, 2, 1, 30, 40, 7, 2'b01, 1, 1, 2, 1, 0};
    vt[4]  = '{2'b11, 50, 60, 2, 30, 40, 7, 2'b10, 1, 30, 40, 7, 0};
    vt[5]  = '{2'b11, 50, 60, 2, 100, 110, 3, 2'b01, 1, 50, 60, 2, 0};
    vt[6]  = '{2'b10, 0, 0, 0, 160, 5, 1, 2'b10, 0, 50, 60, 2, 1};
    vt[7]  = '{2'b01, 159, 119, 4, 0, 0, 0, 2'b01, 1, 159, 119, 4, 1};
    vt[8]  = '{2'b01, 0, 120, 3, 0, 0, 0, 2'b01, 0, 159, 119, 4, 1};
    vt[9]  = '{2'b11, 7, 8, 1, 9, 10, 2, 2'b10, 1, 9, 10, 2, 1};
    vt[10] = '{2'b01, 11, 12, 3, 0, 0, 0, 2'b01, 1, 11, 12, 3, 1};

    reset          = 1'b1;
    clear_start    = 1'b0;
    clear_colour   = 3'd0;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", {plot, x, y, colour}, 19'd0);
      chk("idle_flags", {bus.req_ready, clear_busy, clear_done, range_err}, 5'd0);
      tick();
    end

    for (int i = 0; i < 11; i++) begin
      bus.req_valid  = vt[i].v;
      bus.req_x      = {vt[i].x1, vt[i].x0};
      bus.req_y      = {vt[i].y1, vt[i].y0};
      bus.req_colour = {vt[i].c1, vt[i].c0};
      #1;
      chk($sformatf("vec%0d_ready", i), bus.req_ready, vt[i].rdy);
      tick();
      chk($sformatf("vec%0d_plot", i), plot, vt[i].plot);
      chk($sformatf("vec%0d_xyc", i), {x, y, colour}, {vt[i].ex, vt[i].ey, vt[i].ec});
      chk($sformatf("vec%0d_err", i), range_err, vt[i].err);
    end
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;

    // rr_ptr is 1 here; it must survive the sweep.
    run_clear(-1, -1, 2'b10);
    chk("err_sticky_after_clear", range_err, 1'b1);

    // rr_ptr is 0 after the post-clear grant to requester 1; re-pulse is ignored.
    run_clear(100, -1, 2'b01);

    // rr_ptr is 1 again; reset must return it to 0.
    run_clear(-1, 5000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Shares the single framebuffer pixel-write port (x, y, colour, plot) of the VGA adapter between NUM_REQ drawing requesters, such as the screen drawer and a key-highlight overlay.
- Requesters are served round-robin, one pixel per cycle, using a valid/ready handshake.
- A built-in clear engine fills the whole 160x120 screen with one colour and has priority over all requesters.
- Outputs are registered and drive the adapter's x/y/colour/plot inputs directly.

Parameters:
- NUM_REQ, 2, number of pixel requesters (2..4)
- WIDTH, 160, screen width in pixels; x valid range 0..WIDTH-1
- HEIGHT, 120, screen height in pixels; y valid range 0..HEIGHT-1

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester pixel valid
- req_ready  out  NUM_REQ  per-requester accept (combinational, one-hot or zero)
- req_x  in  8*NUM_REQ  packed x coordinates; requester i uses bits [8i+7:8i]
- req_y  in  7*NUM_REQ  packed y coordinates; requester i uses bits [7i+6:7i]
- req_colour  in  3*NUM_REQ  packed colours; requester i uses bits [3i+2:3i]
- clear_start  in  1  single-cycle request to clear the screen
- clear_colour  in  3  fill colour, sampled with clear_start
- clear_busy  out  1  high while the clear sweep is running
- clear_done  out  1  one-cycle pulse when the sweep completes
- range_err  out  1  sticky flag: an out-of-range pixel was accepted and dropped
- x  out  8  pixel x to the adapter
- y  out  7  pixel y to the adapter
- colour  out  3  pixel colour to the adapter
- plot  out  1  pixel write enable to the adapter

Behaviour:
- Reset values: x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0, range_err=0, round-robin pointer=0, state=ARB.
- Reset mid-clear aborts the sweep. clear_done is not pulsed.
- States:
  - ARB: normal arbitration.
  - CLEAR: screen sweep.
- ARB, grant selection:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with modulo-NUM_REQ wrap.
  - req_ready = one-hot of grant.
  - req_ready is all-zero if no requester is valid, if clear_start=1 this cycle, or if state is CLEAR.
- Handshake:
  - A transfer occurs on any edge where req_valid[i] and req_ready[i] are both 1.
  - A requester must hold its valid and data stable until it is accepted.
  - Only one transfer per cycle.
- Transfer latency is 1 cycle:
  - After the accepting edge: x, y, colour = the granted requester's fields and plot=1.
  - With no transfer: plot=0 and x/y/colour hold their previous values.
- Pointer update: after a transfer, rr_ptr = (grant+1) mod NUM_REQ. Without a transfer it is unchanged.
- Range check:
  - A transfer with x>=WIDTH or y>=HEIGHT is still accepted (ready=1).
  - It produces plot=0 and sets range_err=1, which stays set until reset.
- Clear priority and start:
  - clear_start=1 in ARB wins over any request that cycle.
  - On that edge E0: state goes to CLEAR, clear_colour is latched, clear_busy=1.
  - Outputs after E0 are plot=1, x=0, y=0, colour=latched colour.
- Clear sweep:
  - One pixel per cycle, x inner (0..WIDTH-1) and y outer (0..HEIGHT-1).
  - Total WIDTH*HEIGHT = 19200 plot cycles.
  - Pixel (159,119) is output after edge E0+19199.
- Clear end:
  - After edge E0+19200: plot=0, clear_busy=0, clear_done=1 for exactly one cycle, state=ARB.
  - req_ready may assert in that same cycle.
- clear_start while in CLEAR is ignored, with no restart and no queueing.
- rr_ptr is preserved across a clear.
- The counters are wide enough for WIDTH-1 and HEIGHT-1 and wrap exactly at those bounds, never beyond.

Test Plan:
1. Reset, then idle: plot=0, x=0, y=0, colour=0, req_ready=00, clear_busy=0, range_err=0 for 10 cycles.
2. Requester 0 alone, valid with (10,20,3b101): req_ready=01 that cycle; the next cycle has plot=1, x=10, y=20, colour=5; the cycle after has plot=0.
3. Both requesters valid continuously, with distinct data: grants alternate 0,1,0,1; plot=1 every cycle; the output data alternates accordingly.
4. Requester 1 sends (160,5,3b001): accepted with req_ready=10; plot stays 0; range_err=1 and remains 1 after further valid pixels.
5. clear_start with clear_colour=3b010 while both requesters are valid:
   - req_ready=00 that cycle and for the whole sweep.
   - Exactly 19200 plot pulses with colour=2, first (0,0) and last (159,119), raster order.
   - clear_done pulses once.
   - Arbitration resumes from the preserved rr_ptr.
6. clear_start pulsed again mid-sweep has no effect (still 19200 pulses total). Reset asserted at pixel ~5000: all outputs return to reset values next cycle and clear_done never pulses.
